// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Drives open-drain clock/data pull-low enables; pads are merged at the top level.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILT_LEN       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            fclk_q, fclk_d;
  logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
  logic            fall;
  logic [8:0]      shreg_q, shreg_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            nack_q, nack_d;

  // fclk only flips after FILT_LEN consecutive samples disagree with it
  always_comb begin
    fclk_d     = fclk_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s2_q != fclk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        fclk_d = ~fclk_q;
        fall   = fclk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    data_oe_d = data_oe_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_start && !busy_q) begin
          shreg_d   = {~^tx_data, tx_data};
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = S_SHIFT;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      default: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (to_cnt_q == TO_LAST) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else if (state_q == S_SHIFT) begin
          // ones shifted in behind the parity bit become the released stop bit
          if (fall) begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = {1'b1, shreg_q[8:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'd9) begin
              state_d = S_ACK;
            end
          end
        end else if (state_q == S_ACK) begin
          if (fall) begin
            nack_d  = dat_s2_q;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          if (fclk_q && dat_s2_q) begin
            done_d  = ~nack_q;
            err_d   = nack_q;
            state_d = S_IDLE;
          end
        end
      end
    endcase
    clk_oe_d = (state_d == S_INHIBIT);
    busy_d   = (state_d != S_IDLE) || done_d || err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      fclk_q     <= 1'b1;
      filt_cnt_q <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
      fclk_q     <= fclk_d;
      filt_cnt_q <= filt_cnt_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      nack_q     <= nack_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
